// File: rtl/parity_rx4.sv
// Serial receiver for 4-bit nibbles framed as start, D0..D3 (LSB first), even parity, stop.
// Frames are delivered with VALID even when flagged; a held-low line yields one framing-error frame.
module parity_rx4 #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       RXD,
    output logic [3:0] DOUT,
    output logic       VALID,
    output logic       PERR,
    output logic       FERR,
    output logic       BUSY
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    logic [1:0]       rst_sync_q;
    logic             rst_n_i;
    logic             sync1_q;
    logic             rs_q;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [1:0]       idx_q,       idx_d;
    logic [3:0]       shift_q,     shift_d;
    logic             perr_pend_q, perr_pend_d;
    logic [3:0]       dout_q,      dout_d;
    logic             perr_q,      perr_d;
    logic             ferr_q,      ferr_d;
    logic             valid_q,     valid_d;

    // Reset asserts asynchronously but releases only on a clock edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n_i = rst_sync_q[1];

    always_ff @(posedge CLK or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b1;
            rs_q    <= 1'b1;
        end else begin
            sync1_q <= RXD;
            rs_q    <= sync1_q;
        end
    end

    always_ff @(posedge CLK or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            shift_q     <= 4'h0;
            perr_pend_q <= 1'b0;
            dout_q      <= 4'h0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            perr_pend_q <= perr_pend_d;
            dout_q      <= dout_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            valid_q     <= valid_d;
        end
    end

    // The counter restarts at every sample point, so it never runs past BIT_LAST.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        idx_d       = idx_q;
        shift_d     = shift_q;
        perr_pend_d = perr_pend_q;
        dout_d      = dout_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        valid_d     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rs_q) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                    state_d = rs_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rs_q, shift_q[3:1]};
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = PARITY;
                end
            end
            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d       = '0;
                    perr_pend_d = rs_q ^ (^shift_q);
                    state_d     = STOP;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    dout_d  = shift_q;
                    perr_d  = perr_pend_q;
                    ferr_d  = !rs_q;
                    state_d = rs_q ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rs_q) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign DOUT  = dout_q;
    assign VALID = valid_q;
    assign PERR  = perr_q;
    assign FERR  = ferr_q;
    assign BUSY  = (state_q != IDLE);

endmodule

// File: tb/tb_parity_rx4.sv
// Self-checking bench for parity_rx4: directed frames plus randomized frames, glitches and breaks,
// each delivered frame compared against a scoreboard built from the frame format rules.
module tb_parity_rx4;

    localparam int CPB = 16;
    // Line fall to VALID: two synchronizer stages, half a bit, six bits, one output register.
    localparam int VALID_LAT = 2 + CPB / 2 + 6 * CPB + 1;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       RXD;
    logic [3:0] DOUT;
    logic       VALID;
    logic       PERR;
    logic       FERR;
    logic       BUSY;

    typedef struct {
        int       cyc;
        logic [3:0] d;
        logic     pe;
        logic     fe;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc_cnt   = 0;
    int         checks    = 0;
    int         errors    = 0;
    logic [3:0] last_dout = 4'h0;
    logic       last_perr = 1'b0;
    logic       last_ferr = 1'b0;

    parity_rx4 #(.CLKS_PER_BIT(CPB)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .RXD  (RXD),
        .DOUT (DOUT),
        .VALID(VALID),
        .PERR (PERR),
        .FERR (FERR),
        .BUSY (BUSY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, observed, expected, cyc_cnt);
        end
    endtask

    // Every VALID must match the oldest outstanding frame of the scoreboard.
    always @(negedge CLK) begin
        if (VALID) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpectedValid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("validCycle", cyc_cnt, e.cyc);
                checkOutput("dout", int'(DOUT), int'(e.d));
                checkOutput("perr", int'(PERR), int'(e.pe));
                checkOutput("ferr", int'(FERR), int'(e.fe));
                checkOutput("validBusy", int'(BUSY), int'(e.fe));
                last_dout = e.d;
                last_perr = e.pe;
                last_ferr = e.fe;
            end
        end
    end

    task automatic applyStimulus(input logic b, input int cycles);
        RXD = b;
        repeat (cycles) @(negedge CLK);
    endtask

    task automatic sendFrame(input logic [3:0] d, input logic p, input logic stp);
        exp_t e;
        e.cyc = cyc_cnt + VALID_LAT;
        e.d   = d;
        e.pe  = (($countones(d) + int'(p)) % 2) != 0;
        e.fe  = !stp;
        exp_q.push_back(e);
        applyStimulus(1'b0, CPB);
        for (int i = 0; i < 4; i++) applyStimulus(d[i], CPB);
        applyStimulus(p, CPB);
        applyStimulus(stp, CPB);
    endtask

    task automatic waitDrain(input string tag);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge CLK);
        checkOutput({tag, "Pending"}, exp_q.size(), 0);
        checkOutput({tag, "DoutHold"}, int'(DOUT), int'(last_dout));
        checkOutput({tag, "PerrHold"}, int'(PERR), int'(last_perr));
        checkOutput({tag, "FerrHold"}, int'(FERR), int'(last_ferr));
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "Dout"}, int'(DOUT), 0);
        checkOutput({tag, "Valid"}, int'(VALID), 0);
        checkOutput({tag, "Perr"}, int'(PERR), 0);
        checkOutput({tag, "Ferr"}, int'(FERR), 0);
        checkOutput({tag, "Busy"}, int'(BUSY), 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RXD   = 1'b1;
        RST_N = 1'b0;
        #1;
        checkReset("reset");
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        applyStimulus(1'b1, 5);

        // Good frame, then a bad-parity frame followed by a good one.
        sendFrame(4'hB, 1'b1, 1'b1);
        waitDrain("frameB");
        sendFrame(4'h6, 1'b1, 1'b1);
        sendFrame(4'h3, 1'b0, 1'b1);
        waitDrain("parity");

        // Break: stop bit low and line held low for 40 bit times.
        sendFrame(4'h5, 1'b0, 1'b0);
        applyStimulus(1'b0, 40 * CPB);
        checkOutput("breakBusy", int'(BUSY), 1);
        applyStimulus(1'b1, 4);
        checkOutput("breakIdle", int'(BUSY), 0);
        waitDrain("break");

        // Short low glitch while idle must be rejected.
        applyStimulus(1'b1, CPB);
        begin
            applyStimulus(1'b0, 3);
            checkOutput("glitchBusy", int'(BUSY), 1);
            applyStimulus(1'b0, 1);
            applyStimulus(1'b1, 7);
            checkOutput("glitchIdle", int'(BUSY), 0);
        end
        applyStimulus(1'b1, CPB);
        waitDrain("glitch");

        // Reset in the middle of D2 of a 4'hA frame; the transmitter is abandoned too.
        applyStimulus(1'b0, CPB);
        applyStimulus(1'b0, CPB);
        applyStimulus(1'b1, CPB);
        applyStimulus(1'b0, CPB / 2);
        RST_N = 1'b0;
        #1;
        checkReset("midReset");
        RXD = 1'b1;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        applyStimulus(1'b1, 5 * CPB);
        sendFrame(4'hC, 1'b0, 1'b1);
        waitDrain("afterReset");

        // Back-to-back frames with no idle time between them.
        sendFrame(4'h1, 1'b1, 1'b1);
        sendFrame(4'h2, 1'b1, 1'b1);
        sendFrame(4'hF, 1'b0, 1'b1);
        waitDrain("b2b");

        // Randomized frames, parity/stop errors, gaps and glitches.
        for (int n = 0; n < 12; n++) begin
            logic [3:0] d;
            logic       bad_p;
            logic       bad_s;
            d     = 4'($urandom_range(0, 15));
            bad_p = ($urandom_range(0, 3) == 0);
            bad_s = ($urandom_range(0, 4) == 0);
            sendFrame(d, logic'($countones(d) % 2) ^ bad_p, !bad_s);
            if (bad_s) begin
                applyStimulus(1'b0, $urandom_range(0, 3) * CPB);
                applyStimulus(1'b1, CPB + $urandom_range(0, 20));
            end else begin
                applyStimulus(1'b1, $urandom_range(0, 40));
            end
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus(1'b0, $urandom_range(1, 6));
                applyStimulus(1'b1, 2 * CPB);
            end
        end
        waitDrain("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_rx4.md
PARITY_RX4 -- requirements
Module: parity_rx4

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, meaning CLK cycles per serial bit (legal range 4..1024); H = CLKS_PER_BIT/2, integer division.
REQ-002 CLK  input  1  single system clock, all state changes on its rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 RXD  input  1  serial line, idle high, asynchronous to CLK.
REQ-005 DOUT  output  4  last received data nibble.
REQ-006 VALID  output  1  one-cycle pulse, frame complete.
REQ-007 PERR  output  1  parity error flag for the last frame.
REQ-008 FERR  output  1  framing (stop-bit) error flag for the last frame.
REQ-009 BUSY  output  1  high while a frame is in progress.

Function
REQ-010 Frame format SHALL be: start(0), D0..D3 LSB first, P, stop(1); P is even parity, i.e. P = D0^D1^D2^D3 (the transmit-side 74HC86-style XOR tree).
REQ-011 RXD SHALL pass through a 2-flop synchronizer; all decisions use synchronized value RS only.
REQ-012 States SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_HIGH, with one bit-timing counter and one 2-bit data index.
REQ-013 IDLE: first cycle s with RS=0 -> START, counter cleared, BUSY=1 from cycle s+1.
REQ-014 START: at cycle s+H, RS=0 -> DATA; RS=1 -> IDLE (glitch rejected, no VALID, flags unchanged).
REQ-015 DATA: bit i (i=0..3) SHALL be sampled at cycle s+H+CLKS_PER_BIT*(i+1) into a shift register; after bit 3 -> PARITY.
REQ-016 PARITY: sample at s+H+5*CLKS_PER_BIT; mismatch with XOR of D0..D3 -> parity error latched for this frame.
REQ-017 STOP: sample at s+H+6*CLKS_PER_BIT; RS=1 -> IDLE; RS=0 -> framing error latched, -> WAIT_HIGH.
REQ-018 On the cycle after the stop sample: DOUT, PERR, FERR updated together, VALID=1 for exactly that one cycle; the frame SHALL be delivered even when PERR or FERR is set.
REQ-019 DOUT, PERR, FERR SHALL hold their values until the next VALID; an aborted (glitch) start never alters them.
REQ-020 WAIT_HIGH: remain until RS=1, then -> IDLE; no start detection while RS stays low (break condition produces exactly one FERR frame).
REQ-021 BUSY SHALL be 1 in START, DATA, PARITY, STOP, WAIT_HIGH and 0 in IDLE.
REQ-022 A new start is accepted the first IDLE cycle with RS=0 after the VALID cycle; back-to-back frames with zero idle bits SHALL be received without loss.
REQ-023 Bit counter SHALL be sized ceil(log2(CLKS_PER_BIT)) bits and never wrap mid-bit.

Reset
REQ-024 RST_N=0 SHALL immediately force: state IDLE, synchronizer flops 1, DOUT=4'h0, VALID=0, PERR=0, FERR=0, BUSY=0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; after release the block waits for a fresh falling edge.
REQ-026 Reset release SHALL be synchronized internally (async assert, sync deassert).

Verification (CLKS_PER_BIT=16, s = first cycle RS=0)
REQ-027 Send data 4'hB with P=1, stop=1 -> VALID single pulse at s+105, DOUT=4'hB, PERR=0, FERR=0, BUSY falls at s+105.
REQ-028 Send 4'h6 with P=1 (wrong) -> VALID at s+105, DOUT=4'h6, PERR=1, FERR=0; following good 4'h3 (P=0) frame clears PERR to 0.
REQ-029 Send 4'h5 with stop=0, hold RXD low 40 bit times -> exactly one VALID, FERR=1, BUSY stays 1 until RXD returns high, no further VALID.
REQ-030 RXD low pulse of 4 cycles while IDLE -> no VALID, BUSY returns 0 by s+9, DOUT/flags unchanged.
REQ-031 Pulse RST_N low during D2 of a 4'hA frame -> outputs zero immediately, no VALID for that frame; next clean 4'hC (P=0) frame -> DOUT=4'hC, PERR=0.
REQ-032 Three back-to-back frames 4'h1, 4'h2, 4'hF with no idle bits -> three VALID pulses 112 cycles apart, DOUT 1, 2, F, no errors.
